// File: rtl/serial_word_streamer.sv
// Parallel-to-serial front end for the 1011 sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock, gapless.
module serial_word_streamer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             flush,
  output logic             i,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  assign last_bit_s = (state_q == SHIFT) && (cnt_q == {CW{1'b0}});
  assign shifted_s  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and handshake; flush overrides any accept.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    if (!rst && !flush && ((state_q == IDLE) || last_bit_s)) begin
      load_ready = 1'b1;
    end else begin
      load_ready = 1'b0;
    end
    accept_s = load_valid && load_ready;

    if (flush) begin
      state_d = IDLE;
      shreg_d = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_d = SHIFT;
            shreg_d = data_in;
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q != {CW{1'b0}}) begin
            shreg_d = shifted_s;
            cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end else if (accept_s) begin
            // Reload on the last bit so the next word follows with no gap.
            shreg_d = data_in;
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            state_d = IDLE;
            shreg_d = {WIDTH{1'b0}};
          end
        end
        default: begin
          state_d = IDLE;
          shreg_d = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  assign i         = (state_q == SHIFT) ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
  assign bit_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign word_done = last_bit_s;

endmodule

// File: tb/tb_serial_word_streamer.sv
// Self-checking bench: an MSB-first and an LSB-first streamer checked every cycle
// against a bit-queue model, plus literal expectations on the captured serial streams.
module tb_serial_word_streamer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         lv0 = 1'b0, lv1 = 1'b0, fl0 = 1'b0, fl1 = 1'b0;
  logic         rdy0, rdy1, i0, i1, bv0, bv1, bz0, bz1, wd0, wd1;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending serial bits per instance, front = bit currently on i.
  bit q0[$];
  bit q1[$];
  // Captured DUT activity.
  bit log0[$];
  bit log1[$];
  int done0 = 0, done1 = 0, rb0 = 0;

  serial_word_streamer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .data_in(d0), .load_valid(lv0), .load_ready(rdy0),
    .flush(fl0), .i(i0), .bit_valid(bv0), .busy(bz0), .word_done(wd0));

  serial_word_streamer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(d1), .load_valid(lv1), .load_ready(rdy1),
    .flush(fl1), .i(i1), .bit_valid(bv1), .busy(bz1), .word_done(wd1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs to the model at the falling edge, log the stream,
  // then advance the model at the rising edge.
  task automatic cyc();
    @(negedge clk);
    chk("i0",    i0,   rst ? 1'b0 : (q0.size() > 0 ? q0[0] : 1'b0));
    chk("bv0",   bv0,  !rst && q0.size() > 0);
    chk("busy0", bz0,  !rst && q0.size() > 0);
    chk("wd0",   wd0,  !rst && q0.size() == 1);
    chk("rdy0",  rdy0, !rst && !fl0 && q0.size() <= 1);
    chk("i1",    i1,   rst ? 1'b0 : (q1.size() > 0 ? q1[0] : 1'b0));
    chk("bv1",   bv1,  !rst && q1.size() > 0);
    chk("busy1", bz1,  !rst && q1.size() > 0);
    chk("wd1",   wd1,  !rst && q1.size() == 1);
    chk("rdy1",  rdy1, !rst && !fl1 && q1.size() <= 1);
    if (bv0) log0.push_back(i0);
    if (bv1) log1.push_back(i1);
    if (wd0) done0++;
    if (wd1) done1++;
    if (bz0 && rdy0) rb0++;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (fl0) q0.delete();
      else begin
        automatic bit acc = lv0 && q0.size() <= 1;
        if (q0.size() > 0) void'(q0.pop_front());
        if (acc) for (int b = W - 1; b >= 0; b--) q0.push_back(d0[b]);
      end
      if (fl1) q1.delete();
      else begin
        automatic bit acc = lv1 && q1.size() <= 1;
        if (q1.size() > 0) void'(q1.pop_front());
        if (acc) for (int b = 0; b < W; b++) q1.push_back(d1[b]);
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  function automatic logic [31:0] pack0(input int from);
    logic [31:0] v = '0;
    for (int k = from; k < log0.size(); k++) v = {v[30:0], log0[k]};
    return v;
  endfunction

  function automatic logic [31:0] pack1(input int from);
    logic [31:0] v = '0;
    for (int k = from; k < log1.size(); k++) v = {v[30:0], log1[k]};
    return v;
  endfunction

  function automatic int count1011(input int from);
    int c = 0;
    for (int k = from; k + 3 < log0.size(); k++)
      if (log0[k] && !log0[k+1] && log0[k+2] && log0[k+3]) c++;
    return c;
  endfunction

  int m0, m1, dn0, dn1, r0;

  initial begin
    // Reset: load_ready low while held.
    run(2);
    chk("rdy_in_reset", rdy0, 1'b0);
    rst = 1'b0;
    run(2);
    chk("rdy_after_reset", rdy0, 1'b1);
    chk("i_idle", i0, 1'b0);

    // Single word, MSB first.
    m0 = log0.size(); dn0 = done0;
    d0 = 8'b1011_0110; lv0 = 1'b1;
    cyc();
    lv0 = 1'b0; d0 = 8'hFF;
    run(10);
    chk("single_len", log0.size() - m0, 8);
    chk("single_bits", pack0(m0), 32'h0000_00B6);
    chk("single_done", done0 - dn0, 1);
    chk("single_det", count1011(m0), 2);

    // Back-to-back words with load_valid held.
    m0 = log0.size(); r0 = rb0;
    d0 = 8'hB0; lv0 = 1'b1;
    cyc();
    d0 = 8'h0B;
    run(8);
    lv0 = 1'b0;
    run(10);
    chk("b2b_len", log0.size() - m0, 16);
    chk("b2b_bits", pack0(m0), 32'h0000_B00B);
    chk("b2b_rdy_busy", rb0 - r0, 2);

    // LSB first.
    m1 = log1.size(); dn1 = done1;
    d1 = 8'b0000_1101; lv1 = 1'b1;
    cyc();
    lv1 = 1'b0;
    run(10);
    chk("lsb_len", log1.size() - m1, 8);
    chk("lsb_bits", pack1(m1), 32'h0000_00B0);
    chk("lsb_done", done1 - dn1, 1);

    // Backpressure: new word held from bit 3 until the last-bit cycle.
    m0 = log0.size();
    d0 = 8'h5A; lv0 = 1'b1;
    cyc();
    lv0 = 1'b0;
    run(3);
    d0 = 8'h3C; lv0 = 1'b1;
    run(2);
    d0 = 8'hC3;
    run(3);
    lv0 = 1'b0; d0 = 8'h00;
    run(10);
    chk("bp_len", log0.size() - m0, 16);
    chk("bp_bits", pack0(m0), 32'h0000_5AC3);

    // Reset during bit 4.
    dn0 = done0;
    d0 = 8'hFF; lv0 = 1'b1;
    cyc();
    lv0 = 1'b0;
    run(4);
    rst = 1'b1;
    cyc();
    chk("rst_bv", bv0, 1'b0);
    chk("rst_done", done0 - dn0, 0);
    rst = 1'b0;
    m0 = log0.size(); dn0 = done0;
    d0 = 8'h96; lv0 = 1'b1;
    cyc();
    lv0 = 1'b0;
    run(10);
    chk("post_rst_bits", pack0(m0), 32'h0000_0096);
    chk("post_rst_done", done0 - dn0, 1);

    // Flush during bit 2 with a pending word.
    m0 = log0.size(); dn0 = done0;
    d0 = 8'hA5; lv0 = 1'b1;
    cyc();
    lv0 = 1'b0;
    run(2);
    fl0 = 1'b1; lv0 = 1'b1; d0 = 8'h11;
    cyc();
    fl0 = 1'b0; lv0 = 1'b0;
    cyc();
    chk("flush_busy", bz0, 1'b0);
    chk("flush_rdy", rdy0, 1'b1);
    run(10);
    chk("flush_len", log0.size() - m0, 3);
    chk("flush_bits", pack0(m0), 32'h0000_0005);
    chk("flush_done", done0 - dn0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_word_streamer.md
# serial_word_streamer

Parallel-to-serial front end for the 1011 sequence detector: accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on a serial line that drives the detector's `i` input directly. Supports gapless back-to-back words, so detection patterns spanning word boundaries arrive with no idle bits inserted. It is the stimulus and traffic source placed directly upstream of the detector in the datapath.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 shifts data_in[WIDTH-1] first; 0 shifts data_in[0] first.
- IDLE_LEVEL, 0: value driven on `i` when no word is being shifted.

- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to serialize; sampled only on accept.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort of the current word.
- i  output  1  serial bit to the detector; registered.
- bit_valid  output  1  `i` carries a data bit this cycle.
- busy  output  1  a word is in flight (state SHIFT).
- word_done  output  1  one-cycle pulse during the last bit of a word.

## Operation
- States: IDLE, SHIFT. Internal: shift register shreg[WIDTH-1:0], bit counter cnt of width clog2(WIDTH).
- Accept = load_valid && load_ready at a posedge.
- IDLE: load_ready=1, i=IDLE_LEVEL, bit_valid=0, busy=0. On accept: shreg<=data_in, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT: i = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); bit_valid=1; busy=1.
  - cnt>0: each posedge shifts shreg one position toward the output end (zero fill) and decrements cnt; load_ready=0.
  - cnt==0 (last bit): load_ready=1, word_done=1. On accept: reload shreg/cnt, stay SHIFT (no gap). No accept: state<=IDLE.
- flush (priority over everything except rst): at posedge, state<=IDLE, shreg<=0, cnt<=0; an accept in the same cycle is discarded (load_ready forced 0 while flush=1).
- data_in changes while not accepting have no effect.
- load_valid with load_ready=0: word is held by upstream; no state change.

## Timing
- Reset values (asserted asynchronously, held while rst=1): state=IDLE, shreg=0, cnt=0, i=IDLE_LEVEL, bit_valid=0, busy=0, word_done=0, load_ready=0 while rst=1, 1 from the first cycle after release.
- Latency: first bit of an accepted word appears on `i` in the cycle immediately after the accept edge.
- A word occupies exactly WIDTH consecutive cycles on `i`; word_done coincides with bit WIDTH-1.
- Throughput: one word per WIDTH cycles with load_valid held high; zero idle cycles between words.
- Reset mid-word: word is lost; no word_done; outputs go to reset values immediately.
- Outputs i, bit_valid, busy, word_done derive only from registers (no combinational path from inputs); load_ready depends combinationally on flush only.
- The detector samples `i` on the same clk edge that advances this block; no extra synchronization.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, send 8'b1011_0110 -> i = 1,0,1,1,0,1,1,0 on 8 consecutive cycles starting one cycle after accept, bit_valid=1 throughout, word_done high only on 8th bit, then i=0, busy=0; downstream detector f fires twice (overlapping 1011 at bits 4 and 7).
- Back-to-back: load_valid held, words 8'hB0 then 8'h0B -> 16 contiguous valid bits 1011_0000_0000_1011, load_ready high only on cycles 8 and 16, no idle cycle between words.
- LSB-first: MSB_FIRST=0, send 8'b0000_1101 -> i = 1,0,1,1,0,0,0,0.
- Backpressure: assert load_valid with new data_in during bit 3 of a word -> not accepted until last-bit cycle; data sampled then is the one serialized.
- Reset mid-word: rst pulse during bit 4 -> i=IDLE_LEVEL, bit_valid=0, no word_done; next word after release serializes cleanly from bit 0.
- Flush: flush=1 during bit 2 with load_valid=1 -> IDLE next cycle, pending word not accepted, load_ready=1 the cycle after flush deasserts.
